if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched instruction to IF/ID over a valid/ready handshake.
- Next-PC is a 2:1 choice between sequential PC+PC_INC and the redirect target (branch/jump) supplied by decode/execute.
- Also absorbs flushes caused by redirects that arrive while a fetch is outstanding.

Parameters:
- DWIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- PC_INC, 4, sequential PC increment.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- redirect  input  1  one-cycle pulse; load redirect_pc and flush the current instruction.
- redirect_pc  input  DWIDTH  branch/jump target; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  DWIDTH  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
- imem_rdata  input  DWIDTH  fetched instruction word.
- if_valid  output  1  if_instr/if_pc are valid.
- if_ready  input  1  IF/ID accepts this cycle.
- if_instr  output  DWIDTH  registered instruction.
- if_pc  output  DWIDTH  PC of if_instr.
- if_pc_plus4  output  DWIDTH  if_pc + PC_INC.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, state=REQ, kill=0.
  - if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+PC_INC.
  - imem_req is 0 while rst_n=0.
  - Reset mid-fetch abandons the outstanding request with no further action; instruction memory must tolerate the abandonment.
- States: REQ, HOLD.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - imem_addr stays stable until imem_ack, even across redirects.
- REQ, imem_ack=1, redirect=0, kill=0:
  - if_instr<=imem_rdata, if_pc<=pc, if_pc_plus4<=pc+PC_INC, if_valid<=1, then HOLD.
  - Minimum latency from request to if_valid is 1 cycle after ack.
- REQ, redirect=1 with no ack:
  - pend_pc<=redirect_pc and kill<=1.
  - Stay in REQ with the address unchanged.
  - A later redirect overwrites pend_pc; the latest one wins.
- REQ, imem_ack=1 with kill=1 or redirect=1:
  - Discard rdata.
  - pc<=redirect_pc if redirect=1 this cycle, else pend_pc.
  - kill<=0, stay in REQ; the new address appears next cycle.
- HOLD:
  - imem_req=0; outputs stay stable while if_ready=0.
  - On if_valid & if_ready: if_valid<=0, pc<=pc+PC_INC, then REQ.
- HOLD, redirect=1: takes priority over if_ready.
  - The held instruction is flushed and IF/ID must ignore it that cycle.
  - if_valid<=0, pc<=redirect_pc, then REQ.
- Arithmetic: pc+PC_INC is modulo 2^DWIDTH; 32'hFFFF_FFFC wraps to 0.
- Throughput: 1 instruction per 2 cycles best case, with a single outstanding request. if_valid never asserts for a killed fetch.

Test Plan:
- Reset with RESET_PC=0, then imem_ack=1 every cycle and if_ready=1 -> imem_addr sequence 0,4,8,C; if_pc matches; if_valid every other cycle.
- Hold if_ready=0 for 5 cycles in HOLD with if_instr=32'h2008_0005 -> if_instr, if_pc and if_valid stay stable; imem_req=0 throughout.
- Fetch at pc=8 with ack delayed 3 cycles and redirect to 32'h40 in the 1st wait cycle -> imem_addr stays 8 until ack, rdata discarded, next imem_addr=0x40, no if_valid for pc 8.
- redirect to 32'h80 in HOLD while if_ready=1 -> if_valid=0 next cycle, next imem_addr=0x80.
- pc=32'hFFFF_FFFC accepted -> next imem_addr=0, if_pc_plus4 of that instruction=0.
- rst_n=0 for 1 cycle while a request is outstanding -> imem_req=0 and if_valid=0 during reset; next request at RESET_PC; late imem_ack data from the abandoned fetch is not delivered.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from imem, hands it to IF/ID.
// Latency: if_valid rises the cycle after imem_ack; best case one instruction every two cycles.
// Backpressure: holds if_instr/if_pc stable while if_ready=0; no new fetch is issued until accepted.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   redirect, redirect_pc   one-cycle branch/jump redirect and its target (low two bits ignored)
//   imem_req/addr/ack/rdata single-outstanding fetch handshake to instruction memory
//   if_valid/if_ready       handshake towards IF/ID
//   if_instr/if_pc/if_pc_plus4  registered instruction, its PC, and PC + PC_INC

module if_fetch_stage #(
    parameter int unsigned        DWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              redirect,
    input  logic [DWIDTH-1:0] redirect_pc,

    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,

    output logic              if_valid,
    input  logic              if_ready,
    output logic [DWIDTH-1:0] if_instr,
    output logic [DWIDTH-1:0] if_pc,
    output logic [DWIDTH-1:0] if_pc_plus4
);

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(PC_INC);

    typedef enum logic {
        S_REQ  = 1'b0,   // request outstanding to imem
        S_HOLD = 1'b1    // instruction held for IF/ID
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] pend_pc;      // redirect target remembered while a fetch is in flight
    logic              kill;         // the in-flight fetch belongs to a flushed path

    logic [DWIDTH-1:0] redirect_tgt;
    logic [DWIDTH-1:0] pc_next_seq;

    // Decoded events for the current cycle
    logic              fetch_accept;  // ack for a live fetch: capture it
    logic              fetch_drop;    // ack for a dead fetch: discard, jump to the new path
    logic              fetch_defer;   // redirect while still waiting: remember target, keep address
    logic              hold_flush;    // redirect while holding: throw away the held instruction
    logic              hold_done;     // IF/ID took the held instruction

    // Targets are always word aligned; force the low bits rather than trusting the source.
    always_comb begin
        redirect_tgt       = redirect_pc;
        redirect_tgt[1:0]  = 2'b00;
    end

    // Wraps naturally at 2^DWIDTH.
    assign pc_next_seq = pc + PC_STEP;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    always_comb begin
        fetch_accept = 1'b0;
        fetch_drop   = 1'b0;
        fetch_defer  = 1'b0;
        hold_flush   = 1'b0;
        hold_done    = 1'b0;
        case (state)
            S_REQ: begin
                fetch_accept = imem_ack && !redirect && !kill;
                fetch_drop   = imem_ack && (redirect || kill);
                fetch_defer  = !imem_ack && redirect;
            end
            S_HOLD: begin
                // A redirect wins over acceptance: IF/ID ignores the flushed word.
                hold_flush   = redirect;
                hold_done    = !redirect && if_valid && if_ready;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (fetch_accept)            state_nxt = S_HOLD;
            S_HOLD:  if (hold_flush || hold_done) state_nxt = S_REQ;
            default:                              state_nxt = S_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // The address is the architectural pc; pc only moves on an ack or out of
    // HOLD, so it stays stable for the whole life of a request, redirects included.
    always_comb begin
        imem_req  = rst_n && (state == S_REQ);
        imem_addr = pc;
    end

    // ------------------------------------------------------------------
    // PC, flush bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
            kill    <= 1'b0;
        end else begin
            if (fetch_defer) begin
                // Latest redirect wins; the in-flight fetch is now dead.
                pend_pc <= redirect_tgt;
                kill    <= 1'b1;
            end

            if (fetch_drop) begin
                // A redirect arriving in the ack cycle is newer than anything pending.
                pc   <= redirect ? redirect_tgt : pend_pc;
                kill <= 1'b0;
            end else if (hold_flush) begin
                pc   <= redirect_tgt;
            end else if (hold_done) begin
                pc   <= pc_next_seq;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= RESET_PC;
            if_pc_plus4 <= RESET_PC + PC_STEP;
        end else begin
            if (fetch_accept) begin
                if_valid    <= 1'b1;
                if_instr    <= imem_rdata;
                if_pc       <= pc;
                if_pc_plus4 <= pc_next_seq;
            end else if (hold_flush || hold_done) begin
                if_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(
        .DWIDTH  (32),
        .RESET_PC(32'h0000_0000),
        .PC_INC  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus4(if_pc_plus4)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        cyc();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
        checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", if_pc_plus4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        imem_ack = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'(k) * 32'd4;
            checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++;
                $display("FAIL seq_req k=%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, a); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_gap k=%0d valid got %b exp 0", k, if_valid); end
            imem_rdata = 32'h1000_0000 + 32'(k);
            cyc();
            checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== 32'h1000_0000 + 32'(k) || if_pc_plus4 !== a + 32'd4) begin errors++;
                $display("FAIL seq_out k=%0d got v=%b pc=%h ins=%h pc4=%h exp v=1 pc=%h ins=%h pc4=%h",
                         k, if_valid, if_pc, if_instr, if_pc_plus4, a, 32'h1000_0000 + 32'(k), a + 32'd4); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold_req k=%0d got %b exp 0", k, imem_req); end
            cyc();
        end
        imem_ack = 1'b0;
    endtask

    // pc is 0x10 in REQ on entry.
    task automatic test_hold_stall();
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; if_ready = 1'b0;
        cyc();
        imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1 || if_instr !== 32'h2008_0005 || if_pc !== 32'h10 || imem_req !== 1'b0) begin errors++;
                $display("FAIL stall i=%0d got v=%b ins=%h pc=%h req=%b exp v=1 ins=20080005 pc=00000010 req=0",
                         i, if_valid, if_instr, if_pc, imem_req); end
            cyc();
        end
        if_ready = 1'b1;
        cyc();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++;
            $display("FAIL stall_release got v=%b req=%b addr=%h exp v=0 req=1 addr=00000014", if_valid, imem_req, imem_addr); end
    endtask

    // pc is 0x14 in REQ on entry.
    task automatic test_hold_redirect();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0014; if_ready = 1'b1;
        cyc();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL hold_pre valid got %b exp 1", if_valid); end
        redirect = 1'b1; redirect_pc = 32'h80;
        cyc();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++;
            $display("FAIL hold_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=00000080", if_valid, imem_req, imem_addr); end
        // Redirect coinciding with an ack: data dropped, low target bits ignored.
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0080; redirect = 1'b1; redirect_pc = 32'h0000_000B;
        cyc();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++;
            $display("FAIL ack_redirect got v=%b addr=%h exp v=0 addr=00000008", if_valid, imem_addr); end
    endtask

    // pc is 8 in REQ on entry.
    task automatic test_redirect_pending();
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++;
            $display("FAIL pend_wait1 got req=%b addr=%h exp req=1 addr=00000008", imem_req, imem_addr); end
        cyc();
        checks++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin errors++;
            $display("FAIL pend_wait2 got addr=%h v=%b exp addr=00000008 v=0", imem_addr, if_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++;
            $display("FAIL pend_drop got v=%b req=%b addr=%h exp v=0 req=1 addr=00000040", if_valid, imem_req, imem_addr); end
        cyc();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL pend_no_valid got %b exp 0", if_valid); end
        // Two redirects while waiting: the later target is the one fetched.
        redirect = 1'b1; redirect_pc = 32'h30;
        cyc();
        redirect_pc = 32'h50;
        cyc();
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0040;
        cyc();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h50 || if_valid !== 1'b0) begin errors++;
            $display("FAIL pend_latest got addr=%h v=%b exp addr=00000050 v=0", imem_addr, if_valid); end
    endtask

    // pc is 0x50 in REQ on entry.
    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        imem_rdata = 32'h0C00_0000; if_ready = 1'b1;
        cyc();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== 32'h0C00_0000) begin errors++;
            $display("FAIL wrap_out got v=%b pc=%h pc4=%h ins=%h exp v=1 pc=fffffffc pc4=00000000 ins=0c000000",
                     if_valid, if_pc, if_pc_plus4, if_instr); end
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    // pc is 0 in REQ on entry.
    task automatic test_reset_midfetch();
        imem_ack = 1'b1; imem_rdata = 32'h0; redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;   // leaves a pending kill
        cyc();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mid_addr got %h exp 00000100", imem_addr); end
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc_plus4 !== 32'h4) begin errors++;
            $display("FAIL mid_rst_state got req=%b v=%b pc4=%h exp req=0 v=0 pc4=00000004", imem_req, if_valid, if_pc_plus4); end
        rst_n = 1'b1; imem_ack = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
            $display("FAIL mid_restart got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; if_ready = 1'b1;
        cyc();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1234_5678 || if_pc !== 32'h0) begin errors++;
            $display("FAIL mid_first_fetch got v=%b ins=%h pc=%h exp v=1 ins=12345678 pc=00000000", if_valid, if_instr, if_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_hold_redirect();
        test_redirect_pending();
        test_wrap();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
